// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner.
//   key_state_t : debounce/repeat FSM state encoding (3-bit)
//   CNT_W       : width of the debounce/repeat cycle counter
package key_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEB_PRESS = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        DEB_REL   = 3'd4
    } key_state_t;

endpackage

// File: rtl/key_pulse_conditioner_if.sv
// Signal bundle between the raw push-button, the conditioner and the
// program-counter logic that consumes its strobes.
//   key_n         : raw active-low button level
//   press_pulse   : one-cycle strobe per accepted press / auto-repeat
//   release_pulse : one-cycle strobe per accepted release
//   key_level     : debounced pressed level
//   press_count   : accepted presses (repeats excluded), wraps at 16 bits
// Modports:
//   master : button/consumer side (drives key_n, observes the strobes)
//   slave  : conditioner side (samples key_n, drives the strobes)
interface key_pulse_conditioner_if;

    logic        key_n;
    logic        press_pulse;
    logic        release_pulse;
    logic        key_level;
    logic [15:0] press_count;

    modport master (
        output key_n,
        input  press_pulse,
        input  release_pulse,
        input  key_level,
        input  press_count
    );

    modport slave (
        input  key_n,
        output press_pulse,
        output release_pulse,
        output key_level,
        output press_count
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs (keys, switches).
//   clk   : destination clock
//   reset : asynchronous active-high reset, loads RESET_VAL into both stages
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_reg <= RESET_VAL;
            sync_reg <= RESET_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/key_pulse_conditioner.sv
// Turns a bouncy active-low push-button into clean single-cycle strobes
// for the program counter: synchronise, debounce press and release, emit
// one press strobe per accepted press (plus optional auto-repeat while
// held), a release strobe, a debounced level and an accepted-press count.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   kif   : slave side of key_pulse_conditioner_if (key_n in, strobes out)
// All outputs are registered; a strobe in cycle t is decided from the
// synchronised key in cycle t-1.
module key_pulse_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
    parameter bit          REPEAT_EN           = 1'b1,
    parameter int unsigned REPEAT_DELAY_CYCLES = 25000000,
    parameter int unsigned REPEAT_RATE_CYCLES  = 5000000
) (
    input  logic                    clk,
    input  logic                    reset,
    key_pulse_conditioner_if.slave  kif
);

    localparam logic [CNT_W-1:0] DEB_LIMIT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DELAY_LIMIT = CNT_W'(REPEAT_DELAY_CYCLES);
    localparam logic [CNT_W-1:0] RATE_LIMIT  = CNT_W'(REPEAT_RATE_CYCLES);

    logic             key_sync;
    logic             pressed_s;

    key_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    logic             press_pulse_reg, press_pulse_next;
    logic             release_pulse_reg, release_pulse_next;
    logic             key_level_reg, key_level_next;
    logic [15:0]      press_count_reg, press_count_next;

    // Synchroniser resets to "released" so reset deassertion never looks
    // like a press edge.
    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kif.key_n),
        .q     (key_sync)
    );

    assign pressed_s = ~key_sync;
    assign cnt_inc   = cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            press_pulse_reg   <= 1'b0;
            release_pulse_reg <= 1'b0;
            key_level_reg     <= 1'b0;
            press_count_reg   <= '0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            press_pulse_reg   <= press_pulse_next;
            release_pulse_reg <= release_pulse_next;
            key_level_reg     <= key_level_next;
            press_count_reg   <= press_count_next;
        end
    end

    // The sample that triggers entry to a debounce state already counts as
    // the first stable sample, so both debounce entries load cnt = 1.
    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        press_pulse_next   = 1'b0;
        release_pulse_next = 1'b0;
        key_level_next     = key_level_reg;
        press_count_next   = press_count_reg;

        unique case (state_reg)
            IDLE: begin
                if (pressed_s) begin
                    state_next = DEB_PRESS;
                    cnt_next   = CNT_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end

            DEB_PRESS: begin
                if (!pressed_s) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_inc == DEB_LIMIT) begin
                    state_next       = HELD;
                    cnt_next         = '0;
                    press_pulse_next = 1'b1;
                    key_level_next   = 1'b1;
                    press_count_next = press_count_reg + 16'd1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            HELD: begin
                if (!pressed_s) begin
                    state_next = DEB_REL;
                    cnt_next   = CNT_W'(1);
                end else if (REPEAT_EN && (cnt_inc == DELAY_LIMIT)) begin
                    state_next       = REPEAT;
                    cnt_next         = '0;
                    press_pulse_next = 1'b1;
                end else begin
                    // Without auto-repeat there is nothing to time here.
                    cnt_next = REPEAT_EN ? cnt_inc : '0;
                end
            end

            REPEAT: begin
                if (!pressed_s) begin
                    state_next = DEB_REL;
                    cnt_next   = CNT_W'(1);
                end else if (cnt_inc == RATE_LIMIT) begin
                    cnt_next         = '0;
                    press_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            DEB_REL: begin
                // A bounce back to pressed returns to HELD silently and
                // restarts the repeat delay from zero.
                if (pressed_s) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_inc == DEB_LIMIT) begin
                    state_next         = IDLE;
                    cnt_next           = '0;
                    key_level_next     = 1'b0;
                    release_pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign kif.press_pulse   = press_pulse_reg;
    assign kif.release_pulse = release_pulse_reg;
    assign kif.key_level     = key_level_reg;
    assign kif.press_count   = press_count_reg;

endmodule
